// File: rtl/mem_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-port block memory arbiter.
package mem_arbiter_pkg;

    // Byte-address width, block width and byte offset within one 32-byte block
    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_SIZE       = 256;
    localparam int CACHE_OFFSET_LEN = 5;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick. While locked, only the dcache (port 1) may win.
// On a tie, the port that was not served last wins.
module arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic locked,
    output logic grant,
    output logic valid
);

    // Combinational grant selection
    always_comb begin
        grant = 1'b0;
        valid = 1'b0;
        if (locked) begin
            grant = 1'b1;
            valid = req1;
        end else if (req0 && req1) begin
            grant = ~last;
            valid = 1'b1;
        end else begin
            grant = req1;
            valid = req0 | req1;
        end
    end

endmodule : arb_rr2

// File: rtl/mem_arbiter.sv
// Arbitrates block refills and write-backs from the icache (port 0) and the
// dcache (port 1) onto a single backing block memory. All outputs are
// registered; requester inputs are sampled only while idle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = WORD_SIZE,
    parameter int BLK_W  = BLOCK_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [BLK_W-1:0]  wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [BLK_W-1:0]  wdata1,
    input  logic              lock1,
    output logic              ack0,
    output logic              ack1,
    output logic [BLK_W-1:0]  rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic              mem_ready,
    input  logic [BLK_W-1:0]  mem_rdata,
    output logic              busy
);

    arb_state_e          state_r;
    arb_state_e          state_nxt_s;
    logic                own_r;
    logic                last_r;
    logic                locked_r;
    logic                ack0_r;
    logic                ack1_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [BLK_W-1:0]    mem_wdata_r;
    logic [BLK_W-1:0]    rdata_r;
    logic                busy_r;

    logic                grant_s;
    logic                valid_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [BLK_W-1:0]    sel_wdata_s;
    logic [ADDR_W-1:0]   aligned_addr_s;

    arb_rr2 u_arb (
        .req0   (req0),
        .req1   (req1),
        .last   (last_r),
        .locked (locked_r),
        .grant  (grant_s),
        .valid  (valid_s)
    );

    // Mux the winning port's request fields and block-align its address
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (grant_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
        aligned_addr_s = {sel_addr_s[ADDR_W-1:CACHE_OFFSET_LEN], {CACHE_OFFSET_LEN{1'b0}}};
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_s) begin
                    state_nxt_s = ST_MEM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture, memory strobes, refill data, acks and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_r       <= 1'b0;
            last_r      <= 1'b1;
            locked_r    <= 1'b0;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rdata_r     <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    if (valid_s) begin
                        own_r       <= grant_s;
                        mem_we_r    <= sel_we_s;
                        mem_addr_r  <= aligned_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        mem_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (!mem_we_r) begin
                            rdata_r <= mem_rdata;
                        end
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        last_r    <= own_r;
                        // Only the dcache may keep the grant, and only while it asks to
                        locked_r  <= own_r & lock1;
                        ack0_r    <= ~own_r;
                        ack1_r    <= own_r;
                    end
                end
                ST_RESP: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    ack0_r    <= 1'b0;
                    ack1_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata     = rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a vector table of single
// transactions plus hand-written tie, locked-pair, spurious-ready and
// reset-during-access sequences.
module tb_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         req0, we0, req1, we1, lock1;
    logic [31:0]  addr0, addr1;
    logic [255:0] wdata0, wdata1;
    logic         ack0, ack1;
    logic [255:0] rdata;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_ready;
    logic [255:0] mem_rdata;
    logic         busy;

    int total_checks;
    int pass_checks;

    mem_arbiter #(.ADDR_W(32), .BLK_W(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .lock1     (lock1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         req0;
        logic         we0;
        logic [31:0]  addr0;
        logic [255:0] wdata0;
        logic         req1;
        logic         we1;
        logic [31:0]  addr1;
        logic [255:0] wdata1;
        int           lat;
        logic [255:0] mrdata;
        int           exp_port;
        logic [31:0]  exp_addr;
        logic         exp_we;
        logic [255:0] exp_wdata;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total_checks++;
        if (act === exp) begin
            pass_checks++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called one step after the edge that entered MEM; leaves the bench in the IDLE cycle.
    task automatic serve_check(input string nm, input int port, input logic [31:0] ea,
                               input logic ew, input logic [255:0] ewd, input int lat,
                               input logic [255:0] mrd, input logic [255:0] erd, input bit drop);
        check({nm, ":mem_req"},   {255'd0, mem_req}, 256'd1);
        check({nm, ":mem_addr"},  {224'd0, mem_addr}, {224'd0, ea});
        check({nm, ":mem_we"},    {255'd0, mem_we}, {255'd0, ew});
        check({nm, ":mem_wdata"}, mem_wdata, ewd);
        check({nm, ":busy_mem"},  {255'd0, busy}, 256'd1);
        for (int i = 1; i < lat; i++) begin
            step();
            check({nm, ":wait_req"},  {255'd0, mem_req}, 256'd1);
            check({nm, ":wait_ack"},  {254'd0, ack1, ack0}, 256'd0);
            check({nm, ":wait_addr"}, {224'd0, mem_addr}, {224'd0, ea});
        end
        mem_ready = 1'b1;
        mem_rdata = mrd;
        step();
        mem_ready = 1'b0;
        check({nm, ":ack0"},      {255'd0, ack0}, {255'd0, (port == 0)});
        check({nm, ":ack1"},      {255'd0, ack1}, {255'd0, (port == 1)});
        check({nm, ":resp_req"},  {255'd0, mem_req}, 256'd0);
        check({nm, ":rdata"},     rdata, erd);
        if (drop) begin
            if (port == 0) req0 = 1'b0;
            else           req1 = 1'b0;
        end
        step();
        check({nm, ":idle_ack"},  {254'd0, ack1, ack0}, 256'd0);
        check({nm, ":idle_busy"}, {255'd0, busy}, 256'd0);
    endtask

    initial begin
        total_checks = 0;
        pass_checks  = 0;
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 256'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 256'd0;
        lock1 = 1'b0; mem_ready = 1'b0; mem_rdata = 256'd0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'd0, 1'b0, 1'b0, 32'd0, 256'd0,
                    3, {8{32'hA5A5_A5A5}}, 0, 32'h0000_1220, 1'b0, 256'd0, {8{32'hA5A5_A5A5}}};
        vecs[1] = '{1'b0, 1'b0, 32'd0, 256'd0, 1'b1, 1'b1, 32'h0000_2000, {4{64'h0123_4567_89AB_CDEF}},
                    2, {8{32'hFFFF_FFFF}}, 1, 32'h0000_2000, 1'b1, {4{64'h0123_4567_89AB_CDEF}}, {8{32'hA5A5_A5A5}}};
        vecs[2] = '{1'b0, 1'b0, 32'd0, 256'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 256'd0,
                    1, {8{32'h3C3C_3C3C}}, 1, 32'hFFFF_FFE0, 1'b0, 256'd0, {8{32'h3C3C_3C3C}}};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_001F, {8{32'hDEAD_BEEF}}, 1'b0, 1'b0, 32'd0, 256'd0,
                    2, {8{32'h1234_5678}}, 0, 32'h0000_0000, 1'b1, {8{32'hDEAD_BEEF}}, {8{32'h3C3C_3C3C}}};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_0044, 256'd0, 1'b0, 1'b0, 32'd0, 256'd0,
                    1, {8{32'h0F0F_0F0F}}, 0, 32'h8000_0040, 1'b0, 256'd0, {8{32'h0F0F_0F0F}}};

        // Reset state
        #2;
        check("rst:mem_req",   {255'd0, mem_req}, 256'd0);
        check("rst:mem_we",    {255'd0, mem_we}, 256'd0);
        check("rst:acks",      {254'd0, ack1, ack0}, 256'd0);
        check("rst:busy",      {255'd0, busy}, 256'd0);
        check("rst:rdata",     rdata, 256'd0);
        check("rst:mem_addr",  {224'd0, mem_addr}, 256'd0);
        check("rst:mem_wdata", mem_wdata, 256'd0);
        step();
        rst_n = 1'b1;
        step();

        // Tie right after reset: port 0 first, then port 1 with req1 held
        req0 = 1'b1; addr0 = 32'h0000_0040;
        req1 = 1'b1; addr1 = 32'h0000_0060;
        step();
        serve_check("tie_p0", 0, 32'h0000_0040, 1'b0, 256'd0, 1, {8{32'h1111_1111}}, {8{32'h1111_1111}}, 1'b1);
        step();
        serve_check("tie_p1", 1, 32'h0000_0060, 1'b0, 256'd0, 1, {8{32'h2222_2222}}, {8{32'h2222_2222}}, 1'b1);

        // Locked pair: dcache write-back then refill ahead of a pending icache request
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0080; wdata1 = {8{32'hCAFE_F00D}}; lock1 = 1'b1;
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0200;
        serve_check("lk_wb", 1, 32'h0000_0080, 1'b1, {8{32'hCAFE_F00D}}, 2,
                    {8{32'hEEEE_EEEE}}, {8{32'h2222_2222}}, 1'b0);
        we1 = 1'b0; addr1 = 32'h0000_0100; wdata1 = 256'd0; lock1 = 1'b0;
        step();
        serve_check("lk_rf", 1, 32'h0000_0100, 1'b0, 256'd0, 1, {8{32'h5A5A_5A5A}}, {8{32'h5A5A_5A5A}}, 1'b1);
        step();
        serve_check("lk_p0", 0, 32'h0000_0200, 1'b0, 256'd0, 1, {8{32'h7777_7777}}, {8{32'h7777_7777}}, 1'b1);

        // Spurious mem_ready while idle
        mem_ready = 1'b1;
        step();
        step();
        check("spur:mem_req", {255'd0, mem_req}, 256'd0);
        check("spur:busy",    {255'd0, busy}, 256'd0);
        check("spur:acks",    {254'd0, ack1, ack0}, 256'd0);
        check("spur:rdata",   rdata, {8{32'h7777_7777}});
        mem_ready = 1'b0;

        // Table-driven single transactions
        for (int v = 0; v < 5; v++) begin
            req0 = vecs[v].req0; we0 = vecs[v].we0; addr0 = vecs[v].addr0; wdata0 = vecs[v].wdata0;
            req1 = vecs[v].req1; we1 = vecs[v].we1; addr1 = vecs[v].addr1; wdata1 = vecs[v].wdata1;
            step();
            serve_check($sformatf("vec%0d", v), vecs[v].exp_port, vecs[v].exp_addr, vecs[v].exp_we,
                        vecs[v].exp_wdata, vecs[v].lat, vecs[v].mrdata, vecs[v].exp_rdata, 1'b1);
        end

        // Reset in the middle of an access
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0300; wdata0 = 256'd0;
        we1 = 1'b0; wdata1 = 256'd0;
        step();
        check("mid:mem_req_before", {255'd0, mem_req}, 256'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("mid:mem_req", {255'd0, mem_req}, 256'd0);
        check("mid:busy",    {255'd0, busy}, 256'd0);
        check("mid:acks",    {254'd0, ack1, ack0}, 256'd0);
        check("mid:rdata",   rdata, 256'd0);
        req1 = 1'b1; addr1 = 32'h0000_0400;
        step();
        check("mid:hold_acks", {254'd0, ack1, ack0}, 256'd0);
        check("mid:hold_req",  {255'd0, mem_req}, 256'd0);
        rst_n = 1'b1;
        step();
        serve_check("post_p0", 0, 32'h0000_0300, 1'b0, 256'd0, 2, {8{32'h9999_9999}}, {8{32'h9999_9999}}, 1'b1);
        step();
        serve_check("post_p1", 1, 32'h0000_0400, 1'b0, 256'd0, 1, {8{32'h6666_6666}}, {8{32'h6666_6666}}, 1'b1);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule : tb_mem_arbiter
